// File: rtl/cache_lookup_stage_if.sv
// rtl/cache_lookup_stage_if.sv - stage-2 request, set-array, array-write and memory-port bundle
interface cache_lookup_stage_if #(
    parameter int WAYS      = 4,
    parameter int LINE_BITS = 256,
    parameter int SET_W     = 4
);
    localparam int OFF_W = $clog2(LINE_BITS / 8);
    localparam int TAG_W = 32 - SET_W - OFF_W;

    logic                      s2_valid;
    logic [31:0]               s2_addr;
    logic [3:0]                s2_rmask;
    logic [3:0]                s2_wmask;
    logic [31:0]               s2_wdata;
    logic [WAYS-1:0]           valid_in;
    logic [WAYS-1:0]           dirty_in;
    logic [WAYS*TAG_W-1:0]     tag_in;
    logic [WAYS*LINE_BITS-1:0] data_in;
    logic [WAYS-2:0]           plru_in;

    logic                      ufp_resp;
    logic [31:0]               ufp_rdata;
    logic                      stall;
    logic [WAYS-2:0]           plru_out;
    logic                      plru_we;
    logic                      arr_we;
    logic [WAYS-1:0]           arr_way;
    logic [LINE_BITS/8-1:0]    arr_bmask;
    logic [LINE_BITS-1:0]      arr_data;
    logic [TAG_W-1:0]          arr_tag;
    logic                      arr_valid;
    logic                      arr_dirty;

    logic [31:0]               dfp_addr;
    logic                      dfp_read;
    logic                      dfp_write;
    logic [LINE_BITS-1:0]      dfp_wdata;
    logic [LINE_BITS-1:0]      dfp_rdata;
    logic                      dfp_resp;

    modport master (
        output s2_valid, s2_addr, s2_rmask, s2_wmask, s2_wdata,
        output valid_in, dirty_in, tag_in, data_in, plru_in,
        output dfp_rdata, dfp_resp,
        input  ufp_resp, ufp_rdata, stall, plru_out, plru_we,
        input  arr_we, arr_way, arr_bmask, arr_data, arr_tag, arr_valid, arr_dirty,
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata
    );

    modport slave (
        input  s2_valid, s2_addr, s2_rmask, s2_wmask, s2_wdata,
        input  valid_in, dirty_in, tag_in, data_in, plru_in,
        input  dfp_rdata, dfp_resp,
        output ufp_resp, ufp_rdata, stall, plru_out, plru_we,
        output arr_we, arr_way, arr_bmask, arr_data, arr_tag, arr_valid, arr_dirty,
        output dfp_addr, dfp_read, dfp_write, dfp_wdata
    );
endinterface

// File: rtl/cache_lookup_stage.sv
// rtl/cache_lookup_stage.sv - cache stage 2: tag compare, hit service, tree-PLRU and miss FSM
module cache_lookup_stage #(
    parameter int WAYS      = 4,
    parameter int LINE_BITS = 256,
    parameter int SET_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    cache_lookup_stage_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_BITS / 8);
    localparam int TAG_W = 32 - SET_W - OFF_W;
    localparam int WORDS = LINE_BITS / 32;
    localparam int BYTES = LINE_BITS / 8;
    localparam int LVL   = $clog2(WAYS);
    localparam int WO_W  = OFF_W - 2;

    typedef enum logic [1:0] {S_LOOKUP, S_WRITEBACK, S_FILL, S_REPLAY} state_t;

    state_t               r_state;
    logic [LVL-1:0]       r_victim;
    logic                 r_dfp_read;
    logic                 r_dfp_write;
    logic [31:0]          r_dfp_addr;
    logic [LINE_BITS-1:0] r_dfp_wdata;

    logic [TAG_W-1:0]     w_tag;
    logic [SET_W-1:0]     w_set;
    logic [WO_W-1:0]      w_word;
    logic                 w_unused_addr;
    logic                 w_req;
    logic                 w_miss;
    logic [31:0]          w_rmask32;
    logic                 w_hit;
    logic [LVL-1:0]       w_hit_way;
    logic [LINE_BITS-1:0] w_hit_line;
    logic [31:0]          w_hit_word;
    logic [WAYS-2:0]      w_plru_upd;
    logic [LVL-1:0]       w_walk;
    logic                 w_has_inv;
    logic [LVL-1:0]       w_inv_way;
    logic [LVL-1:0]       w_victim;
    logic [TAG_W-1:0]     w_vic_tag;
    logic [LINE_BITS-1:0] w_vic_line;
    logic                 w_vic_dirty;

    assign w_tag         = bus.s2_addr[31 -: TAG_W];
    assign w_set         = bus.s2_addr[OFF_W +: SET_W];
    assign w_word        = bus.s2_addr[2 +: WO_W];
    assign w_unused_addr = ^bus.s2_addr[1:0];
    assign w_req         = bus.s2_valid && ((|bus.s2_rmask) || (|bus.s2_wmask));
    assign w_miss        = (r_state == S_LOOKUP) && w_req && !w_hit;
    assign w_rmask32     = {{8{bus.s2_rmask[3]}}, {8{bus.s2_rmask[2]}},
                            {8{bus.s2_rmask[1]}}, {8{bus.s2_rmask[0]}}};

    // Descending scan so the lowest matching way is the one left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_hit_line = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.valid_in[i] && (bus.tag_in[i*TAG_W +: TAG_W] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_way  = LVL'(i);
                w_hit_line = bus.data_in[i*LINE_BITS +: LINE_BITS];
            end
        end
    end

    always_comb begin
        w_hit_word = '0;
        for (int j = 0; j < WORDS; j++) begin
            if (w_word == WO_W'(j)) begin
                w_hit_word = w_hit_line[j*32 +: 32];
            end
        end
    end

    // Heap tree: node (2^l - 1 + k) sits at level l; way bits MSB-first pick the path.
    always_comb begin
        w_plru_upd = bus.plru_in;
        for (int l = 0; l < LVL; l++) begin
            for (int k = 0; k < (1 << l); k++) begin
                if (int'(w_hit_way >> (LVL - l)) == k) begin
                    w_plru_upd[(1 << l) - 1 + k] = ~w_hit_way[LVL - 1 - l];
                end
            end
        end
    end

    always_comb begin
        w_walk = '0;
        for (int l = 0; l < LVL; l++) begin
            for (int k = 0; k < (1 << l); k++) begin
                if (int'(w_walk >> (LVL - l)) == k) begin
                    w_walk[LVL - 1 - l] = bus.plru_in[(1 << l) - 1 + k];
                end
            end
        end
    end

    always_comb begin
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid_in[i]) begin
                w_has_inv = 1'b1;
                w_inv_way = LVL'(i);
            end
        end
        w_victim    = w_has_inv ? w_inv_way : w_walk;
        w_vic_tag   = '0;
        w_vic_line  = '0;
        w_vic_dirty = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_victim == LVL'(i)) begin
                w_vic_tag   = bus.tag_in[i*TAG_W +: TAG_W];
                w_vic_line  = bus.data_in[i*LINE_BITS +: LINE_BITS];
                w_vic_dirty = bus.valid_in[i] && bus.dirty_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOOKUP;
            r_victim    <= '0;
            r_dfp_read  <= 1'b0;
            r_dfp_write <= 1'b0;
            r_dfp_addr  <= '0;
            r_dfp_wdata <= '0;
        end else begin
            case (r_state)
                S_LOOKUP: begin
                    if (w_miss) begin
                        r_victim <= w_victim;
                        if (w_vic_dirty) begin
                            r_state     <= S_WRITEBACK;
                            r_dfp_write <= 1'b1;
                            r_dfp_addr  <= {w_vic_tag, w_set, {OFF_W{1'b0}}};
                            r_dfp_wdata <= w_vic_line;
                        end else begin
                            r_state    <= S_FILL;
                            r_dfp_read <= 1'b1;
                            r_dfp_addr <= {w_tag, w_set, {OFF_W{1'b0}}};
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (bus.dfp_resp) begin
                        r_state     <= S_FILL;
                        r_dfp_write <= 1'b0;
                        r_dfp_read  <= 1'b1;
                        r_dfp_addr  <= {w_tag, w_set, {OFF_W{1'b0}}};
                    end
                end
                S_FILL: begin
                    if (bus.dfp_resp) begin
                        r_state    <= S_REPLAY;
                        r_dfp_read <= 1'b0;
                    end
                end
                S_REPLAY: r_state <= S_LOOKUP;
                default:  r_state <= S_LOOKUP;
            endcase
        end
    end

    // Everything is forced low while rst is high, including the registered memory request.
    always_comb begin
        bus.ufp_resp  = 1'b0;
        bus.ufp_rdata = '0;
        bus.stall     = 1'b0;
        bus.plru_out  = '0;
        bus.plru_we   = 1'b0;
        bus.arr_we    = 1'b0;
        bus.arr_way   = '0;
        bus.arr_bmask = '0;
        bus.arr_data  = '0;
        bus.arr_tag   = '0;
        bus.arr_valid = 1'b0;
        bus.arr_dirty = 1'b0;
        bus.dfp_addr  = '0;
        bus.dfp_read  = 1'b0;
        bus.dfp_write = 1'b0;
        bus.dfp_wdata = '0;
        if (!rst) begin
            case (r_state)
                S_LOOKUP: begin
                    if (w_req && w_hit) begin
                        bus.ufp_resp = 1'b1;
                        bus.plru_we  = 1'b1;
                        bus.plru_out = w_plru_upd;
                        if (|bus.s2_wmask) begin
                            bus.arr_we    = 1'b1;
                            bus.arr_way   = WAYS'(1) << w_hit_way;
                            bus.arr_bmask = BYTES'(bus.s2_wmask) << {w_word, 2'b00};
                            bus.arr_data  = {WORDS{bus.s2_wdata}};
                            bus.arr_tag   = w_tag;
                            bus.arr_valid = 1'b1;
                            bus.arr_dirty = 1'b1;
                        end else begin
                            bus.ufp_rdata = w_hit_word & w_rmask32;
                        end
                    end else if (w_req) begin
                        bus.stall = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    bus.stall     = 1'b1;
                    bus.dfp_write = r_dfp_write;
                    bus.dfp_addr  = r_dfp_addr;
                    bus.dfp_wdata = r_dfp_wdata;
                end
                S_FILL: begin
                    bus.stall    = 1'b1;
                    bus.dfp_read = r_dfp_read;
                    bus.dfp_addr = r_dfp_addr;
                    if (bus.dfp_resp) begin
                        bus.arr_we    = 1'b1;
                        bus.arr_way   = WAYS'(1) << r_victim;
                        bus.arr_bmask = '1;
                        bus.arr_data  = bus.dfp_rdata;
                        bus.arr_tag   = w_tag;
                        bus.arr_valid = 1'b1;
                    end
                end
                default: bus.stall = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_lookup_stage.sv
// tb/tb_cache_lookup_stage.sv - directed scoreboard bench for cache_lookup_stage (4-way and 8-way builds)
module tb_cache_lookup_stage;
    logic clk;
    logic rst;

    cache_lookup_stage_if #(.WAYS(4), .LINE_BITS(256), .SET_W(4)) bus ();
    cache_lookup_stage_if #(.WAYS(8), .LINE_BITS(512), .SET_W(4)) bus8 ();

    cache_lookup_stage #(.WAYS(4), .LINE_BITS(256), .SET_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    cache_lookup_stage #(.WAYS(8), .LINE_BITS(512), .SET_W(4)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave));

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0]  sb[$];
    logic [22:0]  tags[4];
    logic [255:0] lines[4];
    logic [3:0]   valid_v;
    logic [3:0]   dirty_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [511:0] line_pat(input int seed);
        logic [511:0] l;
        for (int j = 0; j < 16; j++) l[j*32 +: 32] = 32'hC0DE_0000 + 32'(seed * 256 + j);
        return l;
    endfunction

    function automatic logic [31:0] mk_addr(input int tag, input int set, input int off,
                                            input int offw);
        return (32'(tag) << (4 + offw)) | (32'(set) << offw) | 32'(off);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load();
        bus.valid_in = valid_v;
        bus.dirty_in = dirty_v;
        for (int i = 0; i < 4; i++) begin
            bus.tag_in[i*23 +: 23]    = tags[i];
            bus.data_in[i*256 +: 256] = lines[i];
        end
    endtask

    task automatic req(input int tag, input int set, input int off, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
        bus.s2_valid = 1'b1;
        bus.s2_addr  = mk_addr(tag, set, off, 5);
        bus.s2_rmask = rm;
        bus.s2_wmask = wm;
        bus.s2_wdata = wd;
    endtask

    // Scoreboard consumer: every completed request must match the oldest expected read data.
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.ufp_resp) begin
            chk("sb_depth_at_resp", 512'(sb.size() > 0), 512'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ufp_rdata", 512'(bus.ufp_rdata), 512'(e));
            end
        end
    end

    task automatic run_miss(input bit wb, input int vic, input logic [22:0] ntag, input int set,
                            input int word, input logic [255:0] nline, input logic [2:0] plru_exp);
        int t_fill0;
        int resp_cyc;
        logic [22:0]  otag;
        logic [255:0] oline;
        otag     = tags[vic];
        oline    = lines[vic];
        t_fill0  = wb ? 3 : 1;
        resp_cyc = -1;
        step();
        req(int'(ntag), set, word * 4, 4'b1111, 4'b0000, 32'h0);
        sb.push_back(nline[word*32 +: 32]);
        @(negedge clk);
        chk("miss_stall", 512'(bus.stall), 512'(1));
        chk("miss_no_resp", 512'(bus.ufp_resp), 512'(0));
        chk("miss_lookup_dfp_idle", 512'(bus.dfp_read | bus.dfp_write), 512'(0));
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            bus.dfp_resp  = (wb && cyc == t_fill0 - 1) || (cyc == t_fill0 + 4);
            bus.dfp_rdata = (cyc == t_fill0 + 4) ? nline : '0;
            if (cyc == t_fill0 + 5) begin
                tags[vic]    = ntag;
                lines[vic]   = nline;
                valid_v[vic] = 1'b1;
                dirty_v[vic] = 1'b0;
                load();
            end
            @(negedge clk);
            chk("dfp_no_overlap", 512'(bus.dfp_read & bus.dfp_write), 512'(0));
            if (cyc < t_fill0) begin
                chk("wb_write", 512'(bus.dfp_write), 512'(1));
                chk("wb_addr", 512'(bus.dfp_addr), 512'(mk_addr(int'(otag), set, 0, 5)));
                chk("wb_wdata", 512'(bus.dfp_wdata), 512'(oline));
            end else if (cyc <= t_fill0 + 4) begin
                chk("fill_read", 512'(bus.dfp_read), 512'(1));
                chk("fill_addr", 512'(bus.dfp_addr), 512'(mk_addr(int'(ntag), set, 0, 5)));
            end
            if (cyc == t_fill0 + 4) begin
                chk("fill_arr_we", 512'(bus.arr_we), 512'(1));
                chk("fill_arr_way", 512'(bus.arr_way), 512'(4'b0001 << vic));
                chk("fill_arr_bmask", 512'(bus.arr_bmask), 512'(32'hFFFF_FFFF));
                chk("fill_arr_data", 512'(bus.arr_data), 512'(nline));
                chk("fill_arr_tag", 512'(bus.arr_tag), 512'(ntag));
                chk("fill_valid_dirty", 512'({bus.arr_valid, bus.arr_dirty}), 512'(2'b10));
                chk("fill_no_plru", 512'(bus.plru_we), 512'(0));
            end
            if (cyc == t_fill0 + 5) begin
                chk("replay_stall", 512'(bus.stall), 512'(1));
                chk("replay_quiet", 512'({bus.dfp_read, bus.dfp_write, bus.arr_we, bus.plru_we}),
                    512'(0));
            end
            if (bus.ufp_resp) begin
                resp_cyc = cyc;
                chk("replay_hit_plru", 512'(bus.plru_out), 512'(plru_exp));
                chk("replay_hit_stall", 512'(bus.stall), 512'(0));
                break;
            end
        end
        chk("miss_latency", 512'(resp_cyc), 512'(t_fill0 + 6));
        bus.dfp_resp = 1'b0;
        step();
        bus.s2_valid = 1'b0;
    endtask

    initial begin
        logic [511:0] tmp;
        logic [511:0] nline8;
        int           resp8;
        rst = 1'b1;
        bus.s2_valid = 1'b0; bus.s2_addr = '0; bus.s2_rmask = '0; bus.s2_wmask = '0;
        bus.s2_wdata = '0; bus.plru_in = '0; bus.dfp_rdata = '0; bus.dfp_resp = 1'b0;
        bus8.s2_valid = 1'b0; bus8.s2_addr = '0; bus8.s2_rmask = '0; bus8.s2_wmask = '0;
        bus8.s2_wdata = '0; bus8.plru_in = '0; bus8.dfp_rdata = '0; bus8.dfp_resp = 1'b0;
        bus8.valid_in = '1; bus8.dirty_in = '0;
        for (int i = 0; i < 8; i++) begin
            bus8.tag_in[i*22 +: 22]    = 22'(32'h2000 + i);
            bus8.data_in[i*512 +: 512] = line_pat(20 + i);
        end
        valid_v = 4'b1111;
        dirty_v = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tags[i]  = 23'(32'h1000 + i);
            tmp      = line_pat(i + 1);
            lines[i] = tmp[255:0];
        end
        load();
        req(32'h1002, 3, 8, 4'b0011, 4'b0000, 32'h0);
        @(negedge clk);
        chk("rst_outputs", 512'({bus.ufp_resp, bus.stall, bus.plru_we, bus.arr_we,
                                 bus.dfp_read, bus.dfp_write}), 512'(0));
        chk("rst_rdata", 512'(bus.ufp_rdata), 512'(0));

        step();
        rst = 1'b0;
        req(32'h1002, 3, 8, 4'b0011, 4'b0000, 32'h0);
        sb.push_back(lines[2][64 +: 32] & 32'h0000_FFFF);
        @(negedge clk);
        chk("rd_hit_resp", 512'(bus.ufp_resp), 512'(1));
        chk("rd_hit_stall", 512'(bus.stall), 512'(0));
        chk("rd_hit_plru_we", 512'(bus.plru_we), 512'(1));
        chk("rd_hit_plru_out", 512'(bus.plru_out), 512'(3'b100));
        chk("rd_hit_no_arr_we", 512'(bus.arr_we), 512'(0));

        step();
        bus.plru_in = 3'b111;
        req(32'h1002, 3, 8, 4'b1111, 4'b0000, 32'h0);
        sb.push_back(lines[2][64 +: 32]);
        @(negedge clk);
        chk("rd_hit_plru_111", 512'(bus.plru_out), 512'(3'b110));

        step();
        bus.plru_in = 3'b000;
        req(32'h1001, 3, 32'h14, 4'b0000, 4'b1100, 32'hDEAD_BEEF);
        sb.push_back(32'h0);
        @(negedge clk);
        chk("wr_hit_resp", 512'(bus.ufp_resp), 512'(1));
        chk("wr_hit_arr_we", 512'(bus.arr_we), 512'(1));
        chk("wr_hit_arr_way", 512'(bus.arr_way), 512'(4'b0010));
        chk("wr_hit_bmask", 512'(bus.arr_bmask), 512'(32'h00C0_0000));
        chk("wr_hit_data", 512'(bus.arr_data), 512'({8{32'hDEAD_BEEF}}));
        chk("wr_hit_tag", 512'(bus.arr_tag), 512'(23'h1001));
        chk("wr_hit_valid_dirty", 512'({bus.arr_valid, bus.arr_dirty}), 512'(2'b11));
        chk("wr_hit_plru", 512'(bus.plru_out), 512'(3'b001));

        step();
        tags[3] = tags[1];
        load();
        req(32'h1001, 3, 0, 4'b1111, 4'b0000, 32'h0);
        sb.push_back(lines[1][31:0]);
        @(negedge clk);
        chk("multi_hit_lowest", 512'(bus.plru_out), 512'(3'b001));

        step();
        tags[3] = 23'h1003;
        load();
        req(32'h1001, 3, 0, 4'b0000, 4'b0000, 32'h0);
        @(negedge clk);
        chk("no_mask_quiet", 512'({bus.ufp_resp, bus.stall, bus.arr_we, bus.plru_we}), 512'(0));

        step();
        req(32'h7777, 3, 0, 4'b1111, 4'b0000, 32'h0);
        bus.s2_valid = 1'b0;
        @(negedge clk);
        chk("no_valid_quiet", 512'({bus.ufp_resp, bus.stall, bus.dfp_read}), 512'(0));

        step();
        valid_v = 4'b1101;
        load();
        tmp = line_pat(9);
        run_miss(1'b0, 1, 23'h2222, 5, 0, tmp[255:0], 3'b001);

        valid_v = 4'b1111;
        dirty_v = 4'b1111;
        load();
        tmp = line_pat(11);
        run_miss(1'b1, 0, 23'h3333, 7, 3, tmp[255:0], 3'b011);

        dirty_v = 4'b1111;
        load();
        step();
        req(32'h4444, 2, 0, 4'b1111, 4'b0000, 32'h0);
        @(negedge clk);
        chk("rst_mid_miss_stall", 512'(bus.stall), 512'(1));
        step();
        @(negedge clk);
        chk("rst_mid_wb_write", 512'(bus.dfp_write), 512'(1));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", 512'({bus.ufp_resp, bus.stall, bus.arr_we, bus.plru_we,
                                     bus.dfp_read, bus.dfp_write}), 512'(0));
        chk("rst_mid_addr", 512'(bus.dfp_addr), 512'(0));
        step();
        rst = 1'b0;
        bus.s2_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 512'({bus.stall, bus.dfp_read, bus.dfp_write}), 512'(0));
        step();
        @(negedge clk);
        chk("post_rst_no_req", 512'({bus.dfp_read, bus.dfp_write}), 512'(0));
        step();
        req(32'h1002, 2, 4, 4'b1111, 4'b0000, 32'h0);
        sb.push_back(lines[2][32 +: 32]);
        @(negedge clk);
        chk("post_rst_hit", 512'(bus.ufp_resp), 512'(1));
        step();
        bus.s2_valid = 1'b0;

        nline8 = line_pat(77);
        resp8  = -1;
        bus8.plru_in  = 7'b1101011;
        bus8.s2_valid = 1'b1;
        bus8.s2_addr  = mk_addr(32'h5555, 9, 40, 6);
        bus8.s2_rmask = 4'b1111;
        @(negedge clk);
        chk("w8_miss_stall", 512'(bus8.stall), 512'(1));
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            bus8.dfp_resp  = (cyc == 3);
            bus8.dfp_rdata = (cyc == 3) ? nline8 : '0;
            if (cyc == 4) begin
                bus8.tag_in[5*22 +: 22]    = 22'h5555;
                bus8.data_in[5*512 +: 512] = nline8;
            end
            @(negedge clk);
            chk("w8_no_write", 512'(bus8.dfp_write), 512'(0));
            if (cyc <= 3) begin
                chk("w8_fill_read", 512'(bus8.dfp_read), 512'(1));
                chk("w8_fill_addr", 512'(bus8.dfp_addr), 512'(mk_addr(32'h5555, 9, 0, 6)));
            end
            if (cyc == 3) begin
                chk("w8_fill_way", 512'({bus8.arr_we, bus8.arr_way}), 512'({1'b1, 8'b0010_0000}));
                chk("w8_fill_data", 512'(bus8.arr_data), nline8);
            end
            if (bus8.ufp_resp) begin
                resp8 = cyc;
                chk("w8_rdata", 512'(bus8.ufp_rdata), 512'(nline8[10*32 +: 32]));
                chk("w8_plru_out", 512'(bus8.plru_out), 512'(7'b1001110));
                break;
            end
        end
        chk("w8_latency", 512'(resp8), 512'(5));
        bus8.dfp_resp = 1'b0;
        step();
        bus8.s2_valid = 1'b0;

        step();
        chk("sb_drained", 512'(sb.size()), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
